// File: rtl/ifu_exec.sv
// RV32IM R-type execute stage: single-cycle ALU, shift-add multiplier, restoring divider.
// Latency: ALU and short-circuit div 1; MUL XLEN/MUL_BITS+1; DIV/REM XLEN+2 cycles.
// Backpressure: one op in flight; in_ready drops until the pending result drains via out_ready.
module ifu_exec #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func3,
    input  logic             in_func7b5,
    input  logic             in_mext,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int SHW     = $clog2(XLEN);
    localparam int CW      = $clog2(XLEN) + 1;
    localparam int MUL_CYC = XLEN / MUL_BITS;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [1:0]          f3_q;
    logic                mul_q;
    logic [TAG_W-1:0]    tag_q;
    logic [XLEN-1:0]     res_q;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [XLEN-1:0]     dvs;
    logic                neg_q, neg_r;

    logic                fire;
    logic                is_mul_in, is_div_in, div_signed_in, b_zero, div_ovf, short_div;
    logic                a_sgn_mul, b_sgn_mul;
    logic [XLEN-1:0]     alu_res, sc_res, a_mag, b_mag;
    logic [SHW-1:0]      shamt;
    logic [2*XLEN-1:0]   a_ext, acc_init, mul_sum, div_nxt;
    logic [XLEN:0]       r_sh, diff;
    logic [XLEN-1:0]     acc_hi, acc_lo;

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign fire      = in_valid && in_ready;
    assign busy      = (state != S_IDLE) || out_valid;
    assign acc_hi    = acc[2*XLEN-1:XLEN];
    assign acc_lo    = acc[XLEN-1:0];

    assign is_mul_in     = in_mext && !in_func3[2];
    assign is_div_in     = in_mext && in_func3[2];
    assign div_signed_in = !in_func3[0];
    assign b_zero        = (in_b == '0);
    assign div_ovf       = div_signed_in && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    assign short_div     = is_div_in && (b_zero || div_ovf);
    assign shamt         = in_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (in_func3)
            3'b000: alu_res = in_func7b5 ? (in_a - in_b) : (in_a + in_b);
            3'b001: alu_res = in_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            3'b100: alu_res = in_a ^ in_b;
            3'b101: begin
                if (in_func7b5) alu_res = $signed(in_a) >>> shamt;
                else            alu_res = in_a >> shamt;
            end
            3'b110: alu_res = in_a | in_b;
            default: alu_res = in_a & in_b;
        endcase
    end

    // Divide-by-zero and signed overflow resolve at issue without iterating.
    assign sc_res = b_zero ? (in_func3[1] ? in_a : '1) : (in_func3[1] ? '0 : in_a);
    assign a_mag  = (div_signed_in && in_a[XLEN-1]) ? -in_a : in_a;
    assign b_mag  = (div_signed_in && in_b[XLEN-1]) ? -in_b : in_b;

    // A signed multiplier's top bit weighs -2^(XLEN-1); pre-load its contribution so
    // only XLEN multiplier bits need to be walked.
    assign a_sgn_mul = (in_func3[1:0] != 2'b11);
    assign b_sgn_mul = !in_func3[1];
    assign a_ext     = {{XLEN{a_sgn_mul & in_a[XLEN-1]}}, in_a};
    assign acc_init  = (b_sgn_mul && in_b[XLEN-1]) ? -{in_a, {XLEN{1'b0}}} : '0;

    always_comb begin
        mul_sum = acc;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier[j]) mul_sum = mul_sum + (mcand << j);
        end
    end

    // acc holds {remainder, dividend/quotient} while dividing.
    assign r_sh    = {acc_hi, acc_lo[XLEN-1]};
    assign diff    = r_sh - {1'b0, dvs};
    assign div_nxt = diff[XLEN] ? {r_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fire) begin
                    if (is_mul_in)                    state_nxt = S_MUL;
                    else if (is_div_in && !short_div) state_nxt = S_DIV;
                    else                              state_nxt = S_DONE;
                end
            end
            S_MUL:   if (cnt == CW'(MUL_CYC - 1)) state_nxt = S_DONE;
            S_DIV:   if (cnt == CW'(XLEN - 1))    state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            f3_q   <= '0;
            mul_q  <= 1'b0;
            tag_q  <= '0;
            res_q  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        f3_q  <= in_func3[1:0];
                        mul_q <= is_mul_in;
                        tag_q <= in_tag;
                        cnt   <= '0;
                        if (is_mul_in) begin
                            acc    <= acc_init;
                            mcand  <= a_ext;
                            mplier <= in_b;
                        end else if (short_div) begin
                            res_q <= sc_res;
                        end else if (is_div_in) begin
                            acc   <= {{XLEN{1'b0}}, a_mag};
                            dvs   <= b_mag;
                            neg_q <= div_signed_in && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                            neg_r <= div_signed_in && in_a[XLEN-1];
                        end else begin
                            res_q <= alu_res;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier >> MUL_BITS;
                    cnt    <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (f3_q[1]) res_q <= neg_r ? -acc_hi : acc_hi;
                    else         res_q <= neg_q ? -acc_lo : acc_lo;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (state == S_DONE) begin
            out_valid  <= 1'b1;
            out_result <= mul_q ? ((f3_q == 2'b00) ? acc_lo : acc_hi) : res_q;
            out_tag    <= tag_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifu_exec.sv
// Scoreboarded bench for ifu_exec: directed corner cases, backpressure, mid-op reset, random ops.
module tb_ifu_exec;
    localparam int XLEN = 32;
    localparam int MB   = 1;
    localparam int TW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_func3;
    logic            in_func7b5;
    logic            in_mext;
    logic [XLEN-1:0] in_a, in_b;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TW-1:0]   out_tag;
    logic            busy;

    ifu_exec #(.XLEN(XLEN), .MUL_BITS(MB), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_func3(in_func3), .in_func7b5(in_func7b5), .in_mext(in_mext),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TW-1:0]   tag;
        int              issue;
        int              lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic and SV division operators.
    task automatic model(input logic [2:0] f3, input logic f7, input logic m,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        logic [63:0] ea, eb, p;
        lat = 1;
        r   = '0;
        if (!m) begin
            case (f3)
                3'd0: r = f7 ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7) r = $signed(a) >>> b[4:0];
                    else    r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (!f3[2]) begin
            ea  = (f3[1:0] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
            eb  = (f3[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
            p   = ea * eb;
            r   = (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
            lat = XLEN / MB + 1;
        end else if (b == 32'd0) begin
            r = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = f3[1] ? 32'd0 : a;
        end else begin
            lat = XLEN + 2;
            if (!f3[0]) begin
                if (f3[1]) r = $signed(a) % $signed(b);
                else       r = $signed(a) / $signed(b);
            end else begin
                if (f3[1]) r = a % b;
                else       r = a / b;
            end
        end
    endtask

    // Drive one op from posedge+1 and hold it until accepted; waits = stall cycles seen.
    task automatic issue(input logic [2:0] f3, input logic f7, input logic m,
                         input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag,
                         input logic [31:0] res, input int lat, output int waits);
        exp_t e;
        bit   done = 0;
        waits      = 0;
        in_valid   = 1'b1;
        in_func3   = f3;
        in_func7b5 = f7;
        in_mext    = m;
        in_a       = a;
        in_b       = b;
        in_tag     = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                waits++;
                if (waits > 300) begin
                    chk("issue_timeout", {31'b0, in_ready}, 32'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        e.res = res; e.tag = tag; e.issue = cyc + 1; e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = TW'($urandom);
    endtask

    task automatic dir(input logic [2:0] f3, input logic f7, input logic m,
                       input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag,
                       input logic [31:0] res, input int lat);
        int w;
        issue(f3, f7, m, a, b, tag, res, lat, w);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: latency at first appearance, hold while stalled, value/tag at handshake.
    logic [31:0]   snap_r;
    logic [TW-1:0] snap_t;
    bit            seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        seen   = 1;
                        snap_r = out_result;
                        snap_t = out_tag;
                        chk("latency", 32'(cyc - q[0].issue), 32'(q[0].lat));
                    end else begin
                        chk("hold_result", out_result, snap_r);
                        chk("hold_tag", 32'(out_tag), 32'(snap_t));
                    end
                    if (out_ready) begin
                        chk("result", out_result, q[0].res);
                        chk("tag", 32'(out_tag), 32'(q[0].tag));
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, lat;
        logic [31:0] r, a, b;
        logic [2:0]  f3;
        logic        f7, m;

        rst = 1'b1; in_valid = 1'b0; in_func3 = '0; in_func7b5 = 1'b0; in_mext = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        dir(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 5'd3, 32'd12, 1);
        dir(3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, 1);
        dir(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd5, 32'hF800_0000, 1);
        dir(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000, 1);
        dir(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1, 1);
        dir(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0, 1);
        dir(3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, XLEN / MB + 1);
        dir(3'b011, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, XLEN / MB + 1);
        dir(3'b000, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'd0, XLEN / MB + 1);
        dir(3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'hFFFF_FFFF, XLEN / MB + 1);
        dir(3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, XLEN + 2);
        dir(3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, XLEN + 2);
        dir(3'b101, 1'b0, 1'b1, 32'd7, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
        dir(3'b111, 1'b0, 1'b1, 32'd7, 32'd0, 5'd16, 32'd7, 1);
        dir(3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
        dir(3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1);
        drain();

        // Backpressure: hold the result five cycles, then release together with a new issue.
        out_ready = 1'b0;
        dir(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 5'd19, 32'd3, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_result", out_result, 32'd3);
            chk("bp_tag", 32'(out_tag), 32'd19);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd20, 32'hFF00_FF00, 1, w);
        chk("bp_accept_on_release", 32'(w), 32'd0);
        drain();

        // Reset ten cycles into a divide.
        dir(3'b100, 1'b0, 1'b1, 32'd100, 32'd7, 5'd21, 32'd14, XLEN + 2);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_stale", {31'b0, out_valid}, 32'd0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) @(posedge clk);
            #1;
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            m  = 1'($urandom_range(0, 1));
            a  = rnd_val();
            b  = rnd_val();
            model(f3, f7, m, a, b, r, lat);
            issue(f3, f7, m, a, b, TW'(i), r, lat, w);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
